fc_pingpong_sched: RTL and testbench
====================================

Name: fc_pingpong_sched

Overview:
- Frame scheduler that sequences the FC-layer input buffer as two ping-pong banks.
- The pooling/flatten writer fills one bank through its enable/done handshake while the FC compute engine consumes the other bank.
- It issues bank base addresses, start pulses and completion status for a run of frame_count frames.
- Sits between the top-level layer controller and the writer/FC-engine pair.

Parameters:
- ADDR_WIDTH, 32, width of bank base addresses.
- BANK_DEPTH, 1024, word offset of bank 1 in the FC data buffer (bank 0 base = 0).
- CNT_WIDTH, 16, width of frame counters and frame_count.
- WD_CYCLES, 65535, watchdog limit, in cycles, for one writer frame.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a run; ignored while busy=1.
- frame_count  in  CNT_WIDTH  frames in the run; sampled when start is accepted.
- writer_en  out  1  level enable to writer; held until writer_done.
- writer_done  in  1  one-cycle pulse from writer: frame written.
- wr_bank  out  1  bank the writer targets.
- wr_base  out  ADDR_WIDTH  wr_bank ? BANK_DEPTH : 0.
- fc_start  out  1  one-cycle pulse: FC engine may read rd_bank.
- fc_done  in  1  one-cycle pulse from FC engine: bank consumed.
- rd_bank  out  1  bank the FC engine reads.
- rd_base  out  ADDR_WIDTH  rd_bank ? BANK_DEPTH : 0.
- busy  out  1  run in progress.
- all_done  out  1  one-cycle pulse when the last frame is consumed.
- timeout_err  out  1  sticky; writer watchdog expired.
- proto_err  out  1  sticky; done pulse received with no matching activity.

Behaviour:
- Reset: every output is 0. Both bank-full bits, wr_bank, rd_bank, counters and watchdog clear. Reset mid-run aborts with no all_done.
- State per bank: full bit (1 = written, not yet consumed).
- Counters: frames_written and frames_read (CNT_WIDTH).
- Writer FSM: W_IDLE, W_ACTIVE, W_GAP, W_WAIT.
  - W_IDLE: start accepted at cycle t → busy=1 at t+1, latch frame_count, clear counters and both err flags. If frame_count=0, all_done pulses at t+1 with busy=0, else enter W_ACTIVE at t+1 (writer_en=1).
  - W_ACTIVE: writer_en=1. writer_done at t → full[wr_bank]=1 at t+1, wr_bank toggles at t+1, frames_written++, writer_en=0 at t+1 (W_GAP).
  - W_GAP: one mandatory low cycle. Then:
    - frames_written=frame_count → W_IDLE (writer side finished);
    - full[wr_bank]=1 → W_WAIT;
    - else → W_ACTIVE.
  - W_WAIT: writer_en=0 until full[wr_bank] clears, then W_ACTIVE next cycle.
- Reader FSM: R_IDLE, R_ACTIVE.
  - R_IDLE with busy and full[rd_bank]=1 → fc_start pulse that cycle, enter R_ACTIVE.
  - Latency: writer_done at t → fc_start at t+1 at earliest.
  - R_ACTIVE: fc_done at t → full[rd_bank]=0 at t+1, rd_bank toggles, frames_read++, R_IDLE.
  - Next fc_start no earlier than t+2.
- Completion: frames_read reaching frame_count → all_done pulse and busy=0 in the same cycle. Both FSMs are idle.
- Simultaneous events:
  - writer_done and fc_done in the same cycle (different banks) are both applied.
  - A bank cleared at t+1 by fc_done lets a W_WAIT writer go W_ACTIVE at t+2.
- Watchdog: counts cycles with writer_en=1; resets on writer_done. Reaching WD_CYCLES:
  - timeout_err=1 (sticky), writer_en=0;
  - both FSMs to idle, busy=0, no all_done.
  - Cleared only by rst or the next accepted start.
- proto_err (sticky; cleared like timeout_err):
  - writer_done while writer_en=0;
  - fc_done while R_IDLE;
  - the pulse is otherwise ignored.
- start while busy: ignored, no error.
- Counter width: frame_count up to 2^CNT_WIDTH-1; counters never wrap within a run.

Test Plan:
- Basic run: frame_count=4, writer_done 5 cycles after each writer_en rise, fc_done 3 cycles after each fc_start → wr_bank sequence 0,1,0,1; rd_bank same order; fc_start 1 cycle after each writer_done; all_done exactly once; busy low same cycle; no errors.
- Back-pressure: frame_count=3, fc_done delayed 50 cycles → after frames 0 and 1, writer sits in W_WAIT with writer_en=0. writer_en rises 2 cycles after the first fc_done; wr_base=0 for frame 2.
- Same-cycle done: writer_done (bank1) and fc_done (bank0) in the same cycle → full={1,0}→ next cycle bank1 full, bank0 empty; writer_en re-rises 2 cycles later; frame count correct.
- Zero/ignored start: frame_count=0 → all_done 1 cycle after start, writer_en never high. A second start while busy does not change the latched count.
- Watchdog with WD_CYCLES=20: writer_done never arrives → timeout_err=1 after 20 cycles of writer_en; writer_en=0 and busy=0 in the same cycle. A new start clears timeout_err.
- Errors/reset: stray fc_done while idle → proto_err=1 sticky. Assert rst for 1 cycle mid-run → all outputs 0 the next cycle; a fresh run then completes normally.

Source files
------------

// File: rtl/fc_pingpong_sched.sv
// fc_pingpong_sched: ping-pong bank scheduler between the FC input-buffer writer and the FC compute engine
module fc_pingpong_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int BANK_DEPTH = 1024,
    parameter int CNT_WIDTH  = 16,
    parameter int WD_CYCLES  = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  writer_en,
    input  logic                  writer_done,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_base,
    output logic                  fc_start,
    input  logic                  fc_done,
    output logic                  rd_bank,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic                  busy,
    output logic                  all_done,
    output logic                  timeout_err,
    output logic                  proto_err
);
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_GAP, W_WAIT} w_state_t;
    typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

    w_state_t             w_state, w_next;
    r_state_t             r_state, r_next;
    logic [1:0]           full;
    logic [CNT_WIDTH-1:0] frame_cnt, frames_written, frames_read;
    logic [WD_W-1:0]      wd;
    logic                 rd_hold;
    logic                 accept, wr_fire, rd_fire, wd_expire, last_read;

    assign writer_en = (w_state == W_ACTIVE);
    // rd_hold keeps the engine's next start at least two cycles after its fc_done
    assign fc_start  = busy && (r_state == R_IDLE) && full[rd_bank] && !rd_hold;
    assign wr_base   = wr_bank ? ADDR_WIDTH'(BANK_DEPTH) : '0;
    assign rd_base   = rd_bank ? ADDR_WIDTH'(BANK_DEPTH) : '0;

    // next-state logic for writer and reader FSMs plus qualified handshake events
    always_comb begin
        accept    = start && !busy;
        wr_fire   = writer_done && writer_en;
        rd_fire   = fc_done && (r_state == R_ACTIVE);
        wd_expire = writer_en && !writer_done && (wd == WD_W'(WD_CYCLES - 1));
        last_read = rd_fire && ((frames_read + CNT_WIDTH'(1)) == frame_cnt);
        w_next    = w_state;
        case (w_state)
            W_IDLE:   if (accept && frame_count != '0) w_next = W_ACTIVE;
            W_ACTIVE: if (wr_fire) w_next = W_GAP;
            W_GAP:    w_next = (frames_written == frame_cnt) ? W_IDLE :
                               full[wr_bank] ? W_WAIT : W_ACTIVE;
            W_WAIT:   if (!full[wr_bank]) w_next = W_ACTIVE;
            default:  w_next = W_IDLE;
        endcase
        r_next = fc_start ? R_ACTIVE : rd_fire ? R_IDLE : r_state;
        if (wd_expire || last_read) begin
            w_next = W_IDLE;
            r_next = R_IDLE;
        end
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // bank occupancy, frame counters, watchdog and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            full           <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            frame_cnt      <= '0;
            frames_written <= '0;
            frames_read    <= '0;
            wd             <= '0;
            rd_hold        <= 1'b0;
            busy           <= 1'b0;
            all_done       <= 1'b0;
            timeout_err    <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            rd_hold  <= rd_fire;
            all_done <= 1'b0;
            if (accept) begin
                busy           <= (frame_count != '0);
                all_done       <= (frame_count == '0);
                frame_cnt      <= frame_count;
                frames_written <= '0;
                frames_read    <= '0;
                wd             <= '0;
                full           <= '0;
                wr_bank        <= 1'b0;
                rd_bank        <= 1'b0;
                rd_hold        <= 1'b0;
                timeout_err    <= 1'b0;
                proto_err      <= 1'b0;
            end else begin
                if (wr_fire) begin
                    full[wr_bank]  <= 1'b1;
                    wr_bank        <= !wr_bank;
                    frames_written <= frames_written + CNT_WIDTH'(1);
                    wd             <= '0;
                end else if (writer_en) begin
                    wd <= wd + WD_W'(1);
                end
                if (rd_fire) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= !rd_bank;
                    frames_read   <= frames_read + CNT_WIDTH'(1);
                end
                if (last_read) begin
                    busy     <= 1'b0;
                    all_done <= 1'b1;
                end
                if (wd_expire) begin
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                end
                if ((writer_done && !writer_en) || (fc_done && r_state == R_IDLE))
                    proto_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fc_pingpong_sched.sv
// tb_fc_pingpong_sched: scoreboard bench with writer/FC responders for fc_pingpong_sched
module tb_fc_pingpong_sched;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, writer_done = 1'b0, fc_done = 1'b0;
    logic [15:0] frame_count = '0;
    logic        writer_en, wr_bank, fc_start, rd_bank, busy, all_done, timeout_err, proto_err;
    logic [31:0] wr_base, rd_base;
    logic [71:0] outv;

    typedef struct {
        logic        bank;
        logic [31:0] base;
        int          lat;
    } ev_t;

    ev_t wq[$], rq[$];
    int  dq[$], tq[$];

    int  n_chk = 0, n_fail = 0, cyc = 0;
    int  last_wd = -1000, last_fd = -1000, last_st = -1000, streak = 0;
    int  w_on = 1, wr_delay = 5, rd_delay = 3, wcnt = 0, rcnt = 0;
    bit  rpend = 0, force_fd = 0, sb_en = 1, en_q = 0, to_q = 0, ok;
    ev_t e;
    int  t;

    fc_pingpong_sched #(.WD_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_count(frame_count),
        .writer_en(writer_en), .writer_done(writer_done), .wr_bank(wr_bank), .wr_base(wr_base),
        .fc_start(fc_start), .fc_done(fc_done), .rd_bank(rd_bank), .rd_base(rd_base),
        .busy(busy), .all_done(all_done), .timeout_err(timeout_err), .proto_err(proto_err)
    );

    assign outv = {writer_en, wr_bank, wr_base, fc_start, rd_bank, rd_base,
                   busy, all_done, timeout_err, proto_err};

    always #5 clk = ~clk;

    task automatic check(string name, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk(logic b, int lat);
        ev_t x;
        x.bank = b;
        x.base = b ? 32'd1024 : 32'd0;
        x.lat  = lat;
        return x;
    endfunction

    task automatic run(int c);
        start       = 1'b1;
        frame_count = 16'(c);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("run_completes_in_budget", busy, 0);
    endtask

    task automatic drain(int exp_to);
        repeat (4) @(negedge clk);
        check("wq_left", wq.size(), 0);
        check("rq_left", rq.size(), 0);
        check("dq_left", dq.size(), 0);
        check("tq_left", tq.size(), 0);
        check("timeout_err", timeout_err, exp_to);
        check("proto_err", proto_err, 0);
    endtask

    // writer model: holds writer_done off until writer_en has been high wr_delay+1 cycles
    initial forever begin
        @(negedge clk);
        writer_done = 1'b0;
        if (writer_en && w_on != 0) begin
            wcnt++;
            if (wcnt == wr_delay + 1) begin
                writer_done = 1'b1;
                wcnt = 0;
            end
        end else wcnt = 0;
    end

    // FC engine model: fc_done rd_delay cycles after each fc_start
    initial forever begin
        @(negedge clk);
        fc_done = force_fd;
        if (!busy) rpend = 0;
        else if (rpend) begin
            rcnt++;
            if (rcnt == rd_delay) begin
                fc_done = 1'b1;
                rpend = 0;
            end
        end
        if (fc_start) begin
            rpend = 1;
            rcnt = 0;
        end
    end

    // monitor: pops expected events as the DUT presents them
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (writer_done) last_wd = cyc - 1;
        if (fc_done) last_fd = cyc - 1;
        if (start) last_st = cyc - 1;
        if (writer_en) streak = en_q ? streak + 1 : 1;
        if (sb_en) begin
            if (writer_en && !en_q) begin
                ok = (wq.size() != 0);
                check("writer_en_rise_expected", ok, 1);
                if (ok) begin
                    e = wq.pop_front();
                    check("wr_bank", wr_bank, e.bank);
                    check("wr_base", wr_base, e.base);
                    if (e.lat >= 0) check("wr_lat_from_fc_done", cyc - last_fd, e.lat);
                end
            end
            if (fc_start) begin
                ok = (rq.size() != 0);
                check("fc_start_expected", ok, 1);
                if (ok) begin
                    e = rq.pop_front();
                    check("rd_bank", rd_bank, e.bank);
                    check("rd_base", rd_base, e.base);
                    if (e.lat >= 0) check("fc_start_lat_from_writer_done", cyc - last_wd, e.lat);
                end
            end
            if (all_done) begin
                ok = (dq.size() != 0);
                check("all_done_expected", ok, 1);
                if (ok) begin
                    t = dq.pop_front();
                    check("busy_at_all_done", busy, 0);
                    if (t >= 0) check("all_done_lat_from_start", cyc - last_st, t);
                end
            end
            if (timeout_err && !to_q) begin
                ok = (tq.size() != 0);
                check("timeout_expected", ok, 1);
                if (ok) begin
                    t = tq.pop_front();
                    check("wd_enable_cycles", streak, t);
                    check("wd_writer_en_low", writer_en, 0);
                    check("wd_busy_low", busy, 0);
                end
            end
        end
        en_q = writer_en;
        to_q = timeout_err;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", $countones(outv), 0);
        rst = 1'b0;
        @(negedge clk);

        // basic run of 4 frames
        wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1)); wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1));
        rq.push_back(mk(0, 1));  rq.push_back(mk(1, 1));  rq.push_back(mk(0, 1));  rq.push_back(mk(1, 1));
        dq.push_back(-1);
        run(4);
        wait_done(200);
        drain(0);

        // back-pressure: slow consumer parks the writer in W_WAIT
        rd_delay = 50;
        wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1)); wq.push_back(mk(0, 2));
        rq.push_back(mk(0, 1));  rq.push_back(mk(1, -1)); rq.push_back(mk(0, -1));
        dq.push_back(-1);
        run(3);
        wait_done(400);
        drain(0);

        // writer_done and fc_done in the same cycle
        rd_delay = 6;
        wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1)); wq.push_back(mk(0, 2));
        rq.push_back(mk(0, 1));  rq.push_back(mk(1, 2));  rq.push_back(mk(0, 3));
        dq.push_back(-1);
        run(3);
        wait_done(200);
        drain(0);

        // zero-frame run, then a start while busy that must be ignored
        rd_delay = 3;
        dq.push_back(1);
        run(0);
        wait_done(10);
        drain(0);
        wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1));
        rq.push_back(mk(0, 1));  rq.push_back(mk(1, 1));
        dq.push_back(-1);
        run(2);
        repeat (3) @(negedge clk);
        run(5);
        wait_done(200);
        drain(0);

        // watchdog: writer never answers
        w_on = 0;
        wq.push_back(mk(0, -1));
        tq.push_back(20);
        run(1);
        wait_done(100);
        drain(1);
        w_on = 1;
        wq.push_back(mk(0, -1));
        rq.push_back(mk(0, 1));
        dq.push_back(-1);
        run(1);
        check("timeout_cleared_by_start", timeout_err, 0);
        wait_done(100);
        drain(0);

        // stray fc_done while idle
        force_fd = 1;
        @(negedge clk);
        force_fd = 0;
        repeat (3) @(negedge clk);
        check("proto_err_set", proto_err, 1);
        repeat (3) @(negedge clk);
        check("proto_err_sticky", proto_err, 1);

        // aborted run: reset mid-run
        sb_en = 0;
        run(4);
        check("proto_err_cleared_by_start", proto_err, 0);
        repeat (15) @(negedge clk);
        check("busy_mid_run", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_en = 1;
        check("reset_mid_run_outputs_zero", $countones(outv), 0);
        @(negedge clk);

        // fresh run after reset
        wq.push_back(mk(0, -1)); wq.push_back(mk(1, -1));
        rq.push_back(mk(0, 1));  rq.push_back(mk(1, 1));
        dq.push_back(-1);
        run(2);
        wait_done(200);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
